multi_hex_scanner: RTL and testbench
====================================

MULTI_HEX_SCANNER -- requirements
Module: multi_hex_scanner

Interface
REQ-001 Parameter DIGITS, default 4, number of hex digits displayed (1..8).
REQ-002 Parameter REFRESH_DIV, default 50000, clk cycles each digit stays enabled (>=2).
REQ-003 Parameter ACTIVE_LOW, default 1; 1 = segments and digit enables driven active-low, 0 = active-high.
REQ-004 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 value  input  4*DIGITS  hex word; nibble k feeds digit k, digit 0 least significant.
REQ-007 load  input  1  one-cycle strobe; value SHALL be sampled when load=1.
REQ-008 seg  output  7  segment pattern, bit order gfedcba, for the currently enabled digit.
REQ-009 dig_en  output  DIGITS  one-hot digit enable, polarity per ACTIVE_LOW.
REQ-010 frame_start  output  1  one-cycle pulse when digit 0 becomes enabled.

Function
REQ-011 Divider counter SHALL count 0..REFRESH_DIV-1 and wrap; tick = counter at REFRESH_DIV-1.
REQ-012 Digit index SHALL advance on tick, DIGITS-1 wrapping to 0.
REQ-013 seg and dig_en SHALL be registered, both updating on the same edge as the digit index, never showing a mixed digit/pattern.
REQ-014 Encoding, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; ACTIVE_LOW=1 inverts all 7 bits.
REQ-015 load SHALL write value into a pending register and set a pending flag; multiple loads within a frame: last wins.
REQ-016 Committed (displayed) register SHALL update from pending only on the edge where the index wraps DIGITS-1 -> 0 (no tearing within a frame).
REQ-017 load asserted on the wrap edge SHALL commit that cycle's value directly at that edge and leave pending clear.
REQ-018 frame_start SHALL pulse high on the same edge that dig_en switches to digit 0.
REQ-019 With DIGITS=1, every tick is a wrap; frame_start pulses every REFRESH_DIV cycles.

Reset
REQ-020 reset_n low SHALL immediately set counter=0, index=0, pending and committed=0, pending flag=0, frame_start=0.
REQ-021 During reset all dig_en bits SHALL be inactive and seg all segments off (both per ACTIVE_LOW).
REQ-022 First rising edge after release SHALL enable digit 0 showing committed nibble 0 and pulse frame_start.
REQ-023 Reset mid-frame SHALL discard the pending value.

Configuration
REQ-024 Macro MULTI_HEX_SCANNER_LZB_EN defined: leading-zero blanking; digits above the highest nonzero nibble of committed SHALL output all segments off (dig_en unchanged); digit 0 never blanked.
REQ-025 Macro undefined: every digit SHALL display its nibble including leading zeros; no blanking logic present.

Structure
REQ-026 Package hex_disp_pkg SHALL hold the 16-entry segment constant table, SEG_OFF constant and the segment-vector typedef.
REQ-027 Sub-module hex_seg_encoder (4-bit nibble -> 7-bit active-high pattern) SHALL be instantiated once; polarity applied in multi_hex_scanner.

Verification (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless stated)
REQ-028 Reset release, no load -> dig_en=1110, seg=0x40, frame_start pulse; dig_en rotates 1101,1011,0111 every 4 cycles.
REQ-029 load value=0x12AF mid-frame -> display unchanged until wrap; then digit0 seg=~0x71=0x0E, digit1 ~0x77=0x08, digit2 ~0x5B=0x24, digit3 ~0x06=0x79.
REQ-030 Two loads 0x1111 then 0x2222 in one frame -> only 0x2222 displayed after wrap; load on wrap edge with 0x3333 -> digit0 shows 0x30 that frame.
REQ-031 LZB_EN defined, value=0x0050 -> digits 3,2 seg=0x7F, digit1=0x12, digit0=0x40; value=0x0000 -> only digit0 shows 0x40.
REQ-032 Reset asserted mid-frame with pending 0xBEEF -> outputs off asynchronously; after release display 0x0000.
REQ-033 ACTIVE_LOW=0, DIGITS=1 -> dig_en=1 constant, seg=0x3F, frame_start every 4 cycles.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
// Segment vectors are bit order gfedcba, active-high inside this package.
package hex_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_seg_encoder.sv
// Nibble to active-high seven-segment pattern (gfedcba).
module hex_seg_encoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/multi_hex_scanner.sv
// Time-multiplexed DIGITS-wide hex display driver with frame-synchronous value commit.
// Optional leading-zero blanking when MULTI_HEX_SCANNER_LZB_EN is defined.
module multi_hex_scanner
  import hex_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam seg_t SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [DIGITS-1:0] DIG_IDLE = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] com_q, com_d;
  logic                started_q, started_d;
  seg_t                seg_q, seg_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                fs_q, fs_d;

  logic                tick, wrap, blank;
  logic [3:0]          nib;
  seg_t                seg_enc, seg_hi;
  logic [DIGITS-1:0]   dig_hi;

  hex_seg_encoder u_enc (
    .nibble (nib),
    .seg    (seg_enc)
  );

  always_comb begin
    tick       = (cnt_q == LAST_CNT);
    wrap       = tick && (idx_q == LAST_IDX);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    com_d      = com_q;
    started_d  = 1'b1;

    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    // A load on the wrap edge bypasses pending so the new frame shows it at once.
    if (wrap) begin
      if (load) begin
        com_d = value;
      end else if (pend_vld_q) begin
        com_d = pend_q;
      end
      pend_d     = '0;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = value;
      pend_vld_d = 1'b1;
    end

    // The first edge out of reset starts a frame just like a wrap does.
    fs_d = wrap || !started_q;

    nib    = 4'h0;
    dig_hi = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib       = com_d[k*4 +: 4];
        dig_hi[k] = 1'b1;
      end
    end
  end

`ifdef MULTI_HEX_SCANNER_LZB_EN
  logic [IDX_W-1:0] top_nz;

  always_comb begin
    top_nz = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (com_d[k*4 +: 4] != 4'h0) top_nz = IDX_W'(k);
    end
    blank = (idx_d > top_nz);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_hi   = blank ? SEG_OFF : seg_enc;
    seg_d    = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    dig_en_d = (ACTIVE_LOW != 0) ? ~dig_hi : dig_hi;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      com_q      <= '0;
      started_q  <= 1'b0;
      seg_q      <= SEG_IDLE;
      dig_en_q   <= DIG_IDLE;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      com_q      <= com_d;
      started_q  <= started_d;
      seg_q      <= seg_d;
      dig_en_q   <= dig_en_d;
      fs_q       <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dig_en      = dig_en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_multi_hex_scanner.sv
// Randomized self-checking bench: 4-digit active-low and 1-digit active-high instances.
module tb_multi_hex_scanner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value;
  logic        load;
  logic [6:0]  seg, seg1;
  logic [3:0]  dig_en;
  logic [0:0]  dig1;
  logic        fs, fs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_hex_scanner #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load),
    .seg(seg), .dig_en(dig_en), .frame_start(fs)
  );

  multi_hex_scanner #(.DIGITS(1), .REFRESH_DIV(4), .ACTIVE_LOW(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .value(value[3:0]), .load(load),
    .seg(seg1), .dig_en(dig1), .frame_start(fs1)
  );

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: n = rising edges since reset release.
  int          n;
  logic [15:0] pend, com;
  bit          flag;
  logic [3:0]  pend1, com1;
  bit          flag1;
  int          exp_idx;
  bit          exp_wrap;
  logic [6:0]  exp_seg, exp_seg1;
  logic [3:0]  exp_dig;
  logic        exp_fs, exp_fs1;

  function automatic bit wrap_at(input int e, input int d);
    return (e % 4 == 0) && ((e / 4) % d == 0);
  endfunction

  task automatic model_reset();
    n = 0; pend = 0; com = 0; flag = 0; pend1 = 0; com1 = 0; flag1 = 0;
  endtask

  task automatic step(input bit ld, input logic [15:0] v);
    bit   w1;
    int   hi;
    logic [6:0] s;
    load  = ld;
    value = v;
    @(posedge clk);
    n++;
    exp_wrap = wrap_at(n, 4);
    w1 = wrap_at(n, 1);
    if (exp_wrap) begin
      if (ld) com = v; else if (flag) com = pend;
      flag = 0;
    end else if (ld) begin
      pend = v; flag = 1;
    end
    if (w1) begin
      if (ld) com1 = v[3:0]; else if (flag1) com1 = pend1;
      flag1 = 0;
    end else if (ld) begin
      pend1 = v[3:0]; flag1 = 1;
    end
    exp_idx = (n / 4) % 4;
    exp_dig = ~(4'b0001 << exp_idx);
    exp_fs  = (n == 1) || exp_wrap;
    s = tbl[com[exp_idx*4 +: 4]];
`ifdef MULTI_HEX_SCANNER_LZB_EN
    hi = 0;
    for (int k = 0; k < 4; k++) if (com[k*4 +: 4] != 0) hi = k;
    if (exp_idx > hi) s = 7'h00;
`else
    hi = 0;
`endif
    exp_seg  = ~s;
    exp_seg1 = tbl[com1];
    exp_fs1  = (n == 1) || w1;
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load = 1'b0; value = 16'h0;
    model_reset();
    #12;
    checks++; if (seg !== 7'h7F || dig_en !== 4'hF || fs !== 1'b0) begin
      errors++; $display("FAIL reset_main got seg=%h dig=%b fs=%b exp seg=7f dig=1111 fs=0", seg, dig_en, fs);
    end
    checks++; if (seg1 !== 7'h00 || dig1 !== 1'b0 || fs1 !== 1'b0) begin
      errors++; $display("FAIL reset_one got seg=%h dig=%b fs=%b exp 00/0/0", seg1, dig1, fs1);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(0, 0);
    checks++; if (seg !== 7'h40 || dig_en !== 4'b1110 || fs !== 1'b1) begin
      errors++; $display("FAIL first_edge got seg=%h dig=%b fs=%b exp seg=40 dig=1110 fs=1", seg, dig_en, fs);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 40; i++) begin
      step(0, 0);
      checks++; if (dig_en !== rot[exp_idx] || seg !== 7'h40 || fs !== exp_fs) begin
        errors++; $display("FAIL rotation n=%0d got dig=%b seg=%h fs=%b exp dig=%b seg=40 fs=%b",
                           n, dig_en, seg, fs, rot[exp_idx], exp_fs);
      end
      checks++; if (dig1 !== 1'b1 || seg1 !== 7'h3F || fs1 !== exp_fs1) begin
        errors++; $display("FAIL single_digit n=%0d got dig=%b seg=%h fs=%b exp 1/3f/%b",
                           n, dig1, seg1, fs1, exp_fs1);
      end
    end
  endtask

  task automatic run_to_wrap(input string tag);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 0);
      if (exp_wrap) got = 1;
    end
    checks++; if (!got) begin
      errors++; $display("FAIL %s wrap_timeout got none exp wrap within 40 edges", tag);
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] c0, c1, c2, c3);
    logic [6:0] c [4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step(0, 0);
      checks++; if (seg !== c[exp_idx] || seg !== exp_seg || dig_en !== exp_dig) begin
        errors++; $display("FAIL %s n=%0d digit%0d got seg=%h dig=%b exp seg=%h dig=%b",
                           tag, n, exp_idx, seg, dig_en, c[exp_idx], exp_dig);
      end
    end
  endtask

  task automatic test_deferred_load();
    run_to_wrap("deferred");
    for (int i = 0; i < 5; i++) step(0, 0);
    step(1, 16'h12AF);
    for (int i = 0; i < 3; i++) begin
      checks++; if (seg !== 7'h40) begin
        errors++; $display("FAIL deferred_no_tear n=%0d got seg=%h exp 40", n, seg);
      end
      step(0, 0);
    end
    run_to_wrap("deferred");
    check_frame("load_12af", 7'h0E, 7'h08, 7'h24, 7'h79);
  endtask

  task automatic test_last_wins();
    run_to_wrap("last_wins");
    step(1, 16'h1111);
    step(0, 0);
    step(1, 16'h2222);
    run_to_wrap("last_wins");
    check_frame("last_wins", ~tbl[2], ~tbl[2], ~tbl[2], ~tbl[2]);
  endtask

  task automatic test_wrap_load();
    for (int i = 0; i < 20 && !wrap_at(n + 1, 4); i++) step(0, 0);
    step(1, 16'h3333);
    checks++; if (seg !== 7'h30 || dig_en !== 4'b1110 || fs !== 1'b1) begin
      errors++; $display("FAIL wrap_load got seg=%h dig=%b fs=%b exp 30/1110/1", seg, dig_en, fs);
    end
    check_frame("wrap_load_frame", 7'h30, 7'h30, 7'h30, 7'h30);
    run_to_wrap("wrap_load");
    check_frame("wrap_load_stays", 7'h30, 7'h30, 7'h30, 7'h30);
  endtask

  task automatic test_blanking();
    step(1, 16'h0050);
    run_to_wrap("blank");
`ifdef MULTI_HEX_SCANNER_LZB_EN
    check_frame("lzb_0050", 7'h40, 7'h12, 7'h7F, 7'h7F);
`else
    check_frame("lz_0050", 7'h40, 7'h12, 7'h40, 7'h40);
`endif
    step(1, 16'h0000);
    run_to_wrap("blank");
`ifdef MULTI_HEX_SCANNER_LZB_EN
    check_frame("lzb_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F);
`else
    check_frame("lz_0000", 7'h40, 7'h40, 7'h40, 7'h40);
`endif
  endtask

  task automatic test_reset_mid();
    run_to_wrap("reset_mid");
    step(0, 0);
    step(1, 16'hBEEF);
    step(0, 0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (seg !== 7'h7F || dig_en !== 4'hF || fs !== 1'b0 || seg1 !== 7'h00 || dig1 !== 1'b0) begin
      errors++; $display("FAIL reset_async got seg=%h dig=%b fs=%b seg1=%h dig1=%b exp 7f/1111/0/00/0",
                         seg, dig_en, fs, seg1, dig1);
    end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (seg !== 7'h7F || dig_en !== 4'hF) begin
      errors++; $display("FAIL reset_hold got seg=%h dig=%b exp 7f/1111", seg, dig_en);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step(0, 0);
      checks++; if (seg !== 7'h40 || dig_en !== exp_dig || fs !== exp_fs || seg1 !== 7'h3F) begin
        errors++; $display("FAIL reset_discard n=%0d got seg=%h dig=%b fs=%b seg1=%h exp 40/%b/%b/3f",
                           n, seg, dig_en, fs, seg1, exp_dig, exp_fs);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 16'($urandom));
      checks++; if (seg !== exp_seg || dig_en !== exp_dig || fs !== exp_fs) begin
        errors++; $display("FAIL random_main n=%0d got seg=%h dig=%b fs=%b exp seg=%h dig=%b fs=%b",
                           n, seg, dig_en, fs, exp_seg, exp_dig, exp_fs);
      end
      checks++; if (seg1 !== exp_seg1 || dig1 !== 1'b1 || fs1 !== exp_fs1) begin
        errors++; $display("FAIL random_one n=%0d got seg=%h dig=%b fs=%b exp seg=%h dig=1 fs=%b",
                           n, seg1, dig1, fs1, exp_seg1, exp_fs1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_deferred_load();
    test_last_wins();
    test_wrap_load();
    test_blanking();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
